// File: rtl/sponge_pkg.sv
// Shared constants and types for the sponge arbiter: state encodings,
// sponge interface widths and the latched request bundle.
package sponge_pkg;

  localparam int SPONGE_DIN_W  = 1024;
  localparam int SPONGE_LEN_W  = 7;
  localparam int SPONGE_DOUT_W = 512;

  localparam logic MODE_SHAKE128 = 1'b0;
  localparam logic MODE_SHAKE256 = 1'b1;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_ISSUE = ARB_ISSUE,
    ST_WAIT  = ARB_WAIT,
    ST_RESP  = ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic [SPONGE_DIN_W-1:0] din;
    logic [SPONGE_LEN_W-1:0] len;
    logic                    mode;
    logic                    last;
  } sponge_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above base_i,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   base_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] rot;
  logic [IDX_W:0]       off;
  logic [IDX_W:0]       sum;

  always_comb begin
    // Rotating the doubled vector puts the base requester at bit 0.
    rot     = {req_i, req_i} >> base_i;
    found_o = |rot[NUM_REQ-1:0];
    off     = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = (IDX_W+1)'(j);
    end
    sum = {1'b0, base_i} + off;
    if (sum >= NREQ_L) sum = sum - NREQ_L;
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/sponge_arbiter.sv
// Round-robin arbiter sharing one SHAKE sponge among NUM_REQ requesters.
// Optional watchdog enabled by defining SPONGE_ARB_TIMEOUT_EN.
module sponge_arbiter
  import sponge_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*SPONGE_DIN_W-1:0] req_din,
  input  logic [NUM_REQ*SPONGE_LEN_W-1:0] req_byte_len,
  input  logic [NUM_REQ-1:0]              req_mode,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_REQ-1:0]              rsp_err,
  output logic [SPONGE_DOUT_W-1:0]        rsp_dout,
  output logic [IDX_W-1:0]                owner,
  output logic                            arb_busy,
  output logic [SPONGE_DIN_W-1:0]         s_din,
  output logic [SPONGE_LEN_W-1:0]         s_byte_len,
  output logic                            s_mode,
  output logic                            s_last,
  output logic                            s_valid,
  input  logic                            s_ack,
  input  logic [SPONGE_DOUT_W-1:0]        s_dout,
  input  logic                            s_done,
  input  logic                            s_busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num
    $error("sponge_arbiter: NUM_REQ must be in 2..8");
  end
  if ((1 << IDX_W) < NUM_REQ) begin : g_chk_idx
    $error("sponge_arbiter: IDX_W too narrow for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("sponge_arbiter: TIMEOUT_CYCLES must be positive");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e               state_q;
  logic [IDX_W-1:0]         rr_ptr_q;
  logic [IDX_W-1:0]         owner_q;
  sponge_req_t              lat_q;
  logic                     s_valid_q;
  logic                     s_done_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [SPONGE_DOUT_W-1:0] rsp_dout_q;

  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_found;
  sponge_req_t              sel_d;
  logic [IDX_W-1:0]         rr_next_d;
  logic [NUM_REQ-1:0]       owner_oh_d;
  logic                     done_rise_d;

`ifdef SPONGE_ARB_TIMEOUT_EN
  localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0]   tmr_q;
  logic [NUM_REQ-1:0] rsp_err_q;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .base_i  (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    sel_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_d.din  = req_din[k*SPONGE_DIN_W +: SPONGE_DIN_W];
        sel_d.len  = req_byte_len[k*SPONGE_LEN_W +: SPONGE_LEN_W];
        sel_d.mode = req_mode[k];
        sel_d.last = req_last[k];
      end
    end
  end

  assign rr_next_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign owner_oh_d  = NUM_REQ'(1) << owner_q;
  // done is a level that stays high from the previous job; only a fresh rise counts.
  assign done_rise_d = s_done & ~s_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lat_q       <= '0;
      s_valid_q   <= 1'b0;
      s_done_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_dout_q  <= '0;
`ifdef SPONGE_ARB_TIMEOUT_EN
      tmr_q       <= '0;
      rsp_err_q   <= '0;
`endif
    end else begin
      s_done_q <= s_done;
      case (state_q)
        ST_IDLE: begin
          if (pick_found && !s_busy) begin
            lat_q     <= sel_d;
            owner_q   <= pick_idx;
            s_valid_q <= 1'b1;
            state_q   <= ST_ISSUE;
`ifdef SPONGE_ARB_TIMEOUT_EN
            tmr_q     <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (s_ack) begin
            s_valid_q <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done_rise_d) begin
            rsp_dout_q  <= s_dout;
            rsp_valid_q <= owner_oh_d;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= '0;
`ifdef SPONGE_ARB_TIMEOUT_EN
          rsp_err_q   <= '0;
`endif
          rr_ptr_q    <= rr_next_d;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef SPONGE_ARB_TIMEOUT_EN
      // Watchdog overrides any ISSUE/WAIT transition taken in the same cycle.
      if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
        if (tmr_q == TMR_LAST) begin
          s_valid_q   <= 1'b0;
          rsp_valid_q <= '0;
          rsp_err_q   <= owner_oh_d;
          state_q     <= ST_RESP;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end
`endif
    end
  end

  assign s_din      = lat_q.din;
  assign s_byte_len = lat_q.len;
  assign s_mode     = lat_q.mode;
  assign s_last     = lat_q.last;
  assign s_valid    = s_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dout   = rsp_dout_q;
  assign owner      = owner_q;
  assign arb_busy   = (state_q != ST_IDLE);
`ifdef SPONGE_ARB_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = '0;
`endif

endmodule
